// File: rtl/inputs_bus_interface_pkg.sv
// Shared types and constants for the push-button/switch input controller.
// Edge-mode encoding, bus FSM states and register word indices.
package inputs_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'b00,
      RISE = 2'b01,
      FALL = 2'b10,
      BOTH = 2'b11
   } edge_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      DONE = 1'b1
   } bus_state_e;

   localparam logic [1:0] REG_ENABLE  = 2'd0;
   localparam logic [1:0] REG_MODE    = 2'd1;
   localparam logic [1:0] REG_PENDING = 2'd2;
   localparam logic [1:0] REG_LEVEL   = 2'd3;

   // True when an accepted level change is one the channel's mode wants reported.
   function automatic logic edge_match(input edge_mode_e mode, input logic rise, input logic fall);
      case (mode)
         RISE:    return rise;
         FALL:    return fall;
         BOTH:    return rise | fall;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/inputs_bus_interface_debouncer.sv
// Per-channel input path: two-flop synchroniser followed by a stability counter.
// rise/fall pulse in the cycle before the edge that updates level.
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_reg;
   logic             sync2_reg;
   logic             level_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             differs;
   logic             accept;

   // The edge that would bring the count to DEBOUNCE_CYCLES accepts the new level
   // instead, so the counter never holds more than DEBOUNCE_CYCLES-1.
   assign differs = (sync2_reg != level_reg);
   assign accept  = differs && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         level_reg <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
         if (!differs) begin
            cnt_reg <= '0;
         end else if (accept) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
         end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   end

   assign level = level_reg;
   assign rise  = accept & sync2_reg;
   assign fall  = accept & ~sync2_reg;

endmodule

// File: rtl/inputs_bus_interface.sv
// Memory-mapped controller for up to 16 debounced inputs with sticky W1C pending
// bits, per-channel edge selection and per-channel / combined interrupts.
module inputs_bus_interface
   import inputs_pkg::*;
#(
   parameter logic [31:0] START_ADDR      = 32'h0,
   parameter int          CHANNELS        = 4,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] irq,
   output logic                irq_any,
   input  logic [31:0]         addr_bus,
   inout  wire logic [31:0]    data_bus,
   input  logic                rd_bus,
   input  logic                wr_bus,
   input  logic [3:0]          data_mask_bus,
   output wire logic           fc_bus
);

   logic [31:0] rel_addr;
   logic        hit;
   logic [1:0]  reg_index;
   logic [1:0]  word_offset;
   logic        read_req;
   logic        write_req;

   assign rel_addr    = addr_bus - START_ADDR;
   assign hit         = (rel_addr[31:4] == 28'd0);
   assign reg_index   = rel_addr[3:2];
   assign word_offset = rel_addr[1:0];
   assign read_req    = rd_bus & hit;
   assign write_req   = wr_bus & hit;

   // Bus handshake: one register update on entry to DONE, then wait for the strobe to drop.
   bus_state_e state_reg;
   bus_state_e state_next;
   logic       update_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      update_en  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (write_req) begin
               state_next = DONE;
               update_en  = 1'b1;
            end
         end
         DONE: begin
            if (!write_req) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Byte-addressed writes land in the word at the lane selected by the offset.
   logic [31:0] wdata;
   logic [3:0]  wlanes;
   logic [31:0] wbits;
   logic        wr_enable;
   logic        wr_mode;
   logic        wr_pending;
   logic        unused_bus_bits;

   assign wdata      = data_bus << {word_offset, 3'b000};
   assign wlanes     = data_mask_bus << word_offset;
   assign wr_enable  = update_en && (reg_index == REG_ENABLE);
   assign wr_mode    = update_en && (reg_index == REG_MODE);
   assign wr_pending = update_en && (reg_index == REG_PENDING);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign wbits[8*gi +: 8] = {8{wlanes[gi]}};
      end
   endgenerate

   assign unused_bus_bits = ^{wdata, wbits};

   logic [CHANNELS-1:0]   level;
   logic [CHANNELS-1:0]   rise;
   logic [CHANNELS-1:0]   fall;
   logic [CHANNELS-1:0]   set_pend;
   logic [CHANNELS-1:0]   enable_reg;
   logic [CHANNELS-1:0]   enable_next;
   logic [2*CHANNELS-1:0] mode_reg;
   logic [2*CHANNELS-1:0] mode_next;
   logic [CHANNELS-1:0]   pending_reg;
   logic [CHANNELS-1:0]   pending_next;

   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debouncer (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn[gi]),
            .level(level[gi]),
            .rise (rise[gi]),
            .fall (fall[gi])
         );

         assign set_pend[gi] = edge_match(edge_mode_e'(mode_reg[2*gi +: 2]), rise[gi], fall[gi]);

         assign enable_next[gi] = (wr_enable && wbits[gi]) ? wdata[gi] : enable_reg[gi];

         assign mode_next[2*gi]   = (wr_mode && wbits[2*gi])   ? wdata[2*gi]   : mode_reg[2*gi];
         assign mode_next[2*gi+1] = (wr_mode && wbits[2*gi+1]) ? wdata[2*gi+1] : mode_reg[2*gi+1];

         // A new event outranks a clear arriving on the same edge.
         assign pending_next[gi] = set_pend[gi] |
                                   (pending_reg[gi] & ~(wr_pending & wbits[gi] & wdata[gi]));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_reg  <= '0;
         mode_reg    <= '0;
         pending_reg <= '0;
      end else begin
         enable_reg  <= enable_next;
         mode_reg    <= mode_next;
         pending_reg <= pending_next;
      end
   end

   assign irq     = pending_reg & enable_reg;
   assign irq_any = |irq;

   logic [31:0] reg_value;
   logic [31:0] rdata;

   always_comb begin
      reg_value = '0;
      case (reg_index)
         REG_ENABLE:  reg_value[CHANNELS-1:0]   = enable_reg;
         REG_MODE:    reg_value[2*CHANNELS-1:0] = mode_reg;
         REG_PENDING: reg_value[CHANNELS-1:0]   = pending_reg;
         REG_LEVEL:   reg_value[CHANNELS-1:0]   = level;
         default:     reg_value = '0;
      endcase
   end

   assign rdata    = reg_value >> {word_offset, 3'b000};
   assign data_bus = read_req ? rdata : 32'bz;
   assign fc_bus   = hit ? (read_req | (state_reg == DONE)) : 1'bz;

endmodule

// File: tb/tb_inputs_bus_interface.sv
// Directed bench for inputs_bus_interface: debounce latency, glitch rejection,
// edge modes, W1C with lane masks, write handshake, address miss and reset abort.
module tb_inputs_bus_interface;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] MISS = 32'h0000_0200;

   logic        clk;
   logic        rst;
   logic [3:0]  btn;
   logic [3:0]  irq;
   logic        irq_any;
   logic [31:0] addr_bus;
   tri1  [31:0] data_bus;   // released bus reads all ones
   logic        rd_bus;
   logic        wr_bus;
   logic [3:0]  data_mask_bus;
   tri0         fc_bus;     // released acknowledge reads zero

   logic        tb_drive;
   logic [31:0] tb_wdata;

   int checks = 0;
   int passed = 0;

   assign data_bus = tb_drive ? tb_wdata : 32'bz;

   inputs_bus_interface #(
      .START_ADDR     (BASE),
      .CHANNELS       (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn          (btn),
      .irq          (irq),
      .irq_any      (irq_any),
      .addr_bus     (addr_bus),
      .data_bus     (data_bus),
      .rd_bus       (rd_bus),
      .wr_bus       (wr_bus),
      .data_mask_bus(data_mask_bus),
      .fc_bus       (fc_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        fc;
      addr_bus = a;
      rd_bus   = 1'b1;
      #1;
      d  = data_bus;
      fc = fc_bus;
      rd_bus = 1'b0;
      check(tag, d, exp);
      $display("read  %s addr=%h data=%h fc=%b", tag, a, d, fc);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      addr_bus      = a;
      tb_wdata      = d;
      data_mask_bus = m;
      tb_drive      = 1'b1;
      wr_bus        = 1'b1;
      step(1);
      wr_bus   = 1'b0;
      tb_drive = 1'b0;
      step(1);
      $display("write addr=%h data=%h mask=%b", a, d, m);
   endtask

   initial begin
      rst = 1'b1; btn = 4'h0; rd_bus = 1'b0; wr_bus = 1'b0;
      addr_bus = BASE; data_mask_bus = 4'h0; tb_drive = 1'b0; tb_wdata = '0;
      step(3);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_irq_any", 32'(irq_any), 32'h0);
      check("rst_data_released", data_bus, 32'hFFFF_FFFF);
      rst = 1'b0;
      step(1);
      check_reg("rst_enable", BASE + 0, 32'h0);
      check_reg("rst_mode", BASE + 4, 32'h0);
      check_reg("rst_pending", BASE + 8, 32'h0);
      check_reg("rst_level", BASE + 12, 32'h0);

      // Rise on channel 0: event exactly six edges after the input change.
      bus_write(BASE + 4, 32'h1, 4'hF);
      bus_write(BASE + 0, 32'h1, 4'hF);
      btn[0] = 1'b1;
      step(5);
      check_reg("lat_pending_early", BASE + 8, 32'h0);
      check("lat_irq_early", 32'(irq), 32'h0);
      step(1);
      check_reg("lat_pending", BASE + 8, 32'h1);
      check("lat_irq", 32'(irq), 32'h1);
      check("lat_irq_any", 32'(irq_any), 32'h1);
      check_reg("lat_level", BASE + 12, 32'h1);

      // Three-cycle glitch on channel 1 with both edges selected.
      bus_write(BASE + 8, 32'h1, 4'hF);
      check_reg("w1c_pending", BASE + 8, 32'h0);
      check("w1c_irq_any", 32'(irq_any), 32'h0);
      bus_write(BASE + 4, 32'h0D, 4'hF);
      btn[1] = 1'b1;
      step(3);
      btn[1] = 1'b0;
      step(8);
      check_reg("glitch_pending", BASE + 8, 32'h0);
      check_reg("glitch_level", BASE + 12, 32'h1);

      // Channel 2: rise while off, then fall with falling mode and irq disabled.
      btn[2] = 1'b1;
      step(8);
      check_reg("ch2_rise_off_pending", BASE + 8, 32'h0);
      check_reg("ch2_level_high", BASE + 12, 32'h5);
      bus_write(BASE + 4, 32'h2D, 4'hF);
      btn[2] = 1'b0;
      step(8);
      check_reg("ch2_fall_pending", BASE + 8, 32'h4);
      check("ch2_fall_irq", 32'(irq), 32'h0);
      check("ch2_fall_irq_any", 32'(irq_any), 32'h0);
      bus_write(BASE + 0, 32'h4, 4'hF);
      check("ch2_enabled_irq", 32'(irq), 32'h4);
      check("ch2_enabled_irq_any", 32'(irq_any), 32'h1);

      // W1C obeys lane masks; a fall on the clearing edge keeps the bit set.
      bus_write(BASE + 8, 32'h4, 4'b0010);
      check_reg("w1c_masked_off", BASE + 8, 32'h4);
      bus_write(BASE + 8, 32'h4, 4'b0001);
      check_reg("w1c_lane0", BASE + 8, 32'h0);
      check("w1c_lane0_irq", 32'(irq), 32'h0);
      btn[2] = 1'b1;
      step(8);
      btn[2] = 1'b0;
      step(5);
      check_reg("collide_before", BASE + 8, 32'h0);
      bus_write(BASE + 8, 32'h4, 4'b0001);
      check_reg("collide_set_wins", BASE + 8, 32'h4);
      check("collide_irq", 32'(irq), 32'h4);

      // Long write strobe: ack from the second cycle, single update.
      addr_bus = BASE + 0; tb_wdata = 32'h3; data_mask_bus = 4'hF;
      tb_drive = 1'b1; wr_bus = 1'b1;
      #1;
      check("hold_fc_cycle1", 32'(fc_bus), 32'h0);
      step(1);
      check("hold_fc_cycle2", 32'(fc_bus), 32'h1);
      tb_wdata = 32'h0;
      step(1);
      check("hold_fc_cycle3", 32'(fc_bus), 32'h1);
      step(2);
      check("hold_fc_cycle5", 32'(fc_bus), 32'h1);
      wr_bus = 1'b0; tb_drive = 1'b0;
      step(1);
      check("hold_fc_released", 32'(fc_bus), 32'h0);
      check_reg("hold_single_update", BASE + 0, 32'h3);
      check("hold_irq", 32'(irq), 32'h0);

      // Byte lanes and read shifting on MODE; LEVEL ignores writes.
      bus_write(BASE + 5, 32'hFF, 4'b0001);
      check_reg("mode_byte1_write", BASE + 4, 32'h2D);
      bus_write(BASE + 4, 32'h31, 4'b0001);
      check_reg("mode_byte0_write", BASE + 4, 32'h31);
      check_reg("mode_read_offset1", BASE + 5, 32'h0);
      bus_write(BASE + 12, 32'h0, 4'hF);
      check_reg("level_readonly", BASE + 12, 32'h1);

      // Address miss leaves both bus lines released.
      addr_bus = MISS; rd_bus = 1'b1;
      #1;
      check("miss_data", data_bus, 32'hFFFF_FFFF);
      check("miss_fc", 32'(fc_bus), 32'h0);
      rd_bus = 1'b0;

      // Reset during a channel-3 debounce and a DONE write.
      bus_write(BASE + 4, 32'h71, 4'hF);
      btn[3] = 1'b1;
      step(3);
      addr_bus = BASE + 0; tb_wdata = 32'hF; data_mask_bus = 4'hF;
      tb_drive = 1'b1; wr_bus = 1'b1;
      step(1);
      check("abort_fc_done", 32'(fc_bus), 32'h1);
      rst = 1'b1;
      #1;
      check("abort_fc_idle", 32'(fc_bus), 32'h0);
      check("abort_irq", 32'(irq), 32'h0);
      wr_bus = 1'b0; tb_drive = 1'b0;
      step(2);
      rst = 1'b0;
      check_reg("abort_enable", BASE + 0, 32'h0);
      check_reg("abort_mode", BASE + 4, 32'h0);
      check_reg("abort_pending", BASE + 8, 32'h0);
      check_reg("abort_level", BASE + 12, 32'h0);
      bus_write(BASE + 4, 32'h41, 4'hF);
      step(3);
      check_reg("post_rst_pending_early", BASE + 8, 32'h0);
      check_reg("post_rst_level_early", BASE + 12, 32'h0);
      step(1);
      check_reg("post_rst_pending", BASE + 8, 32'h9);
      check_reg("post_rst_level", BASE + 12, 32'h9);
      check("post_rst_irq", 32'(irq), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/inputs_bus_interface.md
# inputs_bus_interface

Memory-mapped controller for up to 16 push-button/switch inputs. It is the parametrised successor of the four-button interface. Each channel has a synchroniser, a debouncer and a selectable edge mode, and sets a sticky write-1-to-clear pending bit. The block sits on the system bus next to the other device interfaces and drives per-channel and combined interrupt lines to the interrupt controller.

## Interface
- START_ADDR, 32'h0, base byte address; decodes 4 word registers (16 bytes)
- CHANNELS, 4, number of inputs; legal 1..16
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a level change is accepted; ≥1
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn  in  CHANNELS  raw asynchronous inputs, bit i = channel i
- irq  out  CHANNELS  per-channel interrupt, irq[i] = PENDING[i] & ENABLE[i]
- irq_any  out  1  OR of irq
- addr_bus  in  32  bus address
- data_bus  inout  32  bus data; driven only during a read hit, otherwise high-Z
- rd_bus, wr_bus  in  1  read / write strobes
- data_mask_bus  in  4  byte-lane mask for writes
- fc_bus  out  1  function-complete; high-Z when the address misses

## Operation
- Register map (reg_index = word index, byte access via word_offset as for other devices):
  - 0 ENABLE: R/W. Bits [CHANNELS-1:0] hold the irq enables.
  - 1 MODE: R/W. Two bits per channel at [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
  - 2 PENDING: R/W1C. Writing 1 clears the bit; writing 0 has no effect.
  - 3 LEVEL: RO. Debounced levels. Writes complete normally with no effect.
- Unimplemented bits read 0 and ignore writes. Byte-lane masking applies to every write, including W1C.
- Channel path:
  - 2-flop synchroniser, then debounce counter.
  - When the synchronised value differs from the debounced level, the counter increments. Otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - An accepted 0→1 change is a rise event and an accepted 1→0 change is a fall event. An event matching MODE sets PENDING on the same edge.
- PENDING is set independently of ENABLE. ENABLE only gates irq.
- Same-cycle set and W1C clear of one bit: set wins.
- Bus FSM, states IDLE and DONE:
  - IDLE → DONE on write hit. The register update happens on that edge.
  - DONE → IDLE when the write request drops.
  - Only one update per write request.
- Reads are combinational: data_bus = register >> (8·word_offset), and fc_bus = 1 while the read hits.
- On a hit, fc_bus = read_req | (state == DONE).

## Timing
- Reset values:
  - ENABLE, MODE, PENDING, debounced levels, synchronisers and counters are all 0.
  - State is IDLE and irq / irq_any are 0.
  - data_bus and fc_bus are high-Z.
- Reset asserted mid-debounce or mid-write aborts immediately; no partial update survives.
- Input held high through reset: after release it produces a rise event, which sets PENDING only if MODE already selects rising or both.
- Latency: a raw input stable from edge k sets PENDING and irq on edge k+2+DEBOUNCE_CYCLES. This breaks down as 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges. Exact timing is verified in scenario 1.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event and no LEVEL change.
- Write acknowledge: fc_bus rises one edge after wr_bus asserts with a hit, and stays high until wr_bus drops.
- Read acknowledge: same cycle as the hit.
- Counter width is $clog2(DEBOUNCE_CYCLES+1). It must not wrap.

## Structure
- Package inputs_pkg holds:
  - edge_mode_e (OFF, RISE, FALL, BOTH)
  - register index constants REG_ENABLE/MODE/PENDING/LEVEL
  - bus_state_e (IDLE, DONE)
- Sub-module input_debouncer (parameter DEBOUNCE_CYCLES) is instantiated per channel in a generate loop. Ports: clk, rst, raw, level, rise, fall.
- Reuse the existing addr_splitter (2 index bits) and data_shifter.

## Test plan
- CHANNELS=4, DEBOUNCE_CYCLES=4, MODE[0]=01, ENABLE=1: raise btn[0] and hold → PENDING=0x1 and irq[0]=irq_any=1 exactly 6 edges later; LEVEL reads 0x1.
- btn[1] pulse of 3 synchronised cycles with MODE=both → no event; PENDING=0, LEVEL=0.
- MODE[2]=10, ENABLE[2]=0, release held btn[2] → PENDING=0x4 and irq=0. Then write ENABLE=0x4 → irq[2]=1.
- Write PENDING=0x4 with data_mask_bus=4'b0001 → PENDING=0. Repeat with a fall event landing on the write edge → bit stays 1.
- Write-handshake checks:
  - Hold wr_bus 5 cycles → fc_bus=1 from the second cycle onward, exactly one update.
  - Byte write to MODE offset 1 → only bits [15:8] change.
  - Miss address → fc_bus and data_bus high-Z.
- Assert rst during debounce of btn[3] and during a DONE write → all registers 0, state IDLE, no event after release until a full debounce completes.
